// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Multi-cycle control unit for a small RV32I subset (R, I-ALU, LOAD, STORE,
// BRANCH). An instruction is latched into IR in FETCH and then stepped
// through DECODE / EXEC / MEM / WB. All datapath controls are decoded from
// the current state and IR only. Any opcode outside the supported set parks
// the controller in HALT, which only reset can leave.
//
// Ports
//   clk           : clock, rising edge
//   reset         : asynchronous, active-high; returns to FETCH, clears IR/counters
//   run           : sampled only in FETCH; high latches ROM_inst and starts an instruction
//   ROM_inst      : instruction word from the instruction ROM
//   status        : ALU flags {N,Z,C,V}; Z (bit 2) resolves BEQ/BNE
//   pc_en         : PC load enable, one cycle in the final state of each instruction
//   PCSrc         : 1 = PC+imm (taken branch), 0 = PC+4
//   RegWrite      : register-file write enable (WB only)
//   ALUSrc        : 1 = imm_32, 0 = rs2 data
//   ALU_operation : 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
//   write         : data-RAM write enable (STORE in MEM)
//   MemtoReg      : 0 = RAM read data, 1 = ALU result
//   immselect     : 00 I-type, 01 S-type, 10 B-type
//   halted        : high while in HALT
//   retired       : count of completed instructions, wraps
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [31:0]      ROM_inst,
  input  logic [3:0]       status,
  output logic             pc_en,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [3:0]       ALU_operation,
  output logic             write,
  output logic             MemtoReg,
  output logic [1:0]       immselect,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t           r_state;
  logic [31:0]      r_ir;
  logic [CNT_W-1:0] r_retired;
  logic             r_halted;

  logic       w_is_r, w_is_i, w_is_load, w_is_store, w_is_branch, w_known;
  logic       w_taken;
  logic [3:0] w_alu_op;
  logic       w_pc_en, w_pcsrc, w_regwrite, w_alusrc, w_write, w_memtoreg;
  logic [3:0] w_alu_out;
  logic [1:0] w_imm;
  logic       w_unused_bits;

  // Fields of IR and status that this controller does not look at.
  assign w_unused_bits = ^{r_ir[31], r_ir[29:15], r_ir[11:7], status[3], status[1:0]};

  // Instruction class from the IR opcode field.
  always_comb begin
    w_is_r      = 1'b0;
    w_is_i      = 1'b0;
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_branch = 1'b0;
    case (r_ir[6:0])
      OP_R:      w_is_r      = 1'b1;
      OP_I:      w_is_i      = 1'b1;
      OP_LOAD:   w_is_load   = 1'b1;
      OP_STORE:  w_is_store  = 1'b1;
      OP_BRANCH: w_is_branch = 1'b1;
      default:   w_is_r      = 1'b0;
    endcase
  end

  assign w_known = w_is_r | w_is_i | w_is_load | w_is_store | w_is_branch;

  // ALU function from funct3/funct7[5]; only R-type may select SUB.
  always_comb begin
    w_alu_op = ALU_ADD;
    if (w_is_r || w_is_i) begin
      case (r_ir[14:12])
        3'b000:  w_alu_op = (w_is_r && r_ir[30]) ? ALU_SUB : ALU_ADD;
        3'b111:  w_alu_op = ALU_AND;
        3'b110:  w_alu_op = ALU_OR;
        3'b010:  w_alu_op = ALU_SLT;
        default: w_alu_op = ALU_ADD;
      endcase
    end else if (w_is_branch) begin
      w_alu_op = ALU_SUB;
    end else begin
      w_alu_op = ALU_ADD;
    end
  end

  // Branch resolution: only BEQ and BNE can be taken.
  always_comb begin
    case (r_ir[14:12])
      3'b000:  w_taken = status[2];
      3'b001:  w_taken = ~status[2];
      default: w_taken = 1'b0;
    endcase
  end

  // Control outputs from state and IR; FETCH/HALT keep the idle values.
  always_comb begin
    w_pc_en    = 1'b0;
    w_pcsrc    = 1'b0;
    w_regwrite = 1'b0;
    w_write    = 1'b0;
    w_memtoreg = 1'b0;
    w_alusrc   = 1'b0;
    w_alu_out  = ALU_ADD;
    w_imm      = 2'b00;
    case (r_state)
      S_DECODE, S_EXEC, S_MEM, S_WB: begin
        w_alu_out = w_alu_op;
        w_alusrc  = w_is_i | w_is_load | w_is_store;
        w_imm     = w_is_store ? 2'b01 : (w_is_branch ? 2'b10 : 2'b00);
      end
      default: w_alu_out = ALU_ADD;
    endcase
    case (r_state)
      S_EXEC: begin
        w_pc_en = w_is_branch;
        w_pcsrc = w_is_branch & w_taken;
      end
      S_MEM: begin
        w_pc_en = w_is_store;
        w_write = w_is_store;
      end
      S_WB: begin
        w_pc_en    = 1'b1;
        w_regwrite = 1'b1;
        w_memtoreg = w_is_r | w_is_i;
      end
      default: w_pc_en = 1'b0;
    endcase
  end

  // Sequencer: state, IR, retired counter and halt flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_ir      <= 32'h0000_0000;
      r_retired <= {CNT_W{1'b0}};
      r_halted  <= 1'b0;
    end else begin
      if (w_pc_en) begin
        r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_retired <= r_retired;
      end
      case (r_state)
        S_FETCH: begin
          if (run) begin
            r_ir    <= ROM_inst;
            r_state <= S_DECODE;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_DECODE: begin
          if (w_known) begin
            r_state <= S_EXEC;
          end else begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end
        end
        S_EXEC: begin
          if (w_is_r || w_is_i) begin
            r_state <= S_WB;
          end else if (w_is_load || w_is_store) begin
            r_state <= S_MEM;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_MEM:   r_state <= w_is_load ? S_WB : S_FETCH;
        S_WB:    r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign pc_en         = w_pc_en;
  assign PCSrc         = w_pcsrc;
  assign RegWrite      = w_regwrite;
  assign ALUSrc        = w_alusrc;
  assign ALU_operation = w_alu_out;
  assign write         = w_write;
  assign MemtoReg      = w_memtoreg;
  assign immselect     = w_imm;
  assign halted        = r_halted;
  assign retired       = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [31:0] ROM_inst;
  logic [3:0]  status;
  logic        pc_en, PCSrc, RegWrite, ALUSrc, write, MemtoReg, halted;
  logic [3:0]  ALU_operation;
  logic [1:0]  immselect;
  logic [15:0] retired;

  // narrow-counter instance used to exercise wrap-around cheaply
  logic       unused_pc_en, unused_pcsrc, unused_rw, unused_src, unused_wr, unused_m2r, unused_halted;
  logic [3:0] unused_alu;
  logic [1:0] unused_imm;
  logic [2:0] s_retired;

  int n_checks = 0;
  int n_fail   = 0;

  int         t_cycles, n_pc, n_rw, n_wr, n_pcsrc;
  logic       t_done;
  logic [3:0] f_alu;
  logic       f_src, f_m2r, f_pcsrc;
  logic [1:0] f_imm;
  logic       d_src;
  logic [1:0] d_imm;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .run(run), .ROM_inst(ROM_inst), .status(status),
    .pc_en(pc_en), .PCSrc(PCSrc), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
    .ALU_operation(ALU_operation), .write(write), .MemtoReg(MemtoReg),
    .immselect(immselect), .halted(halted), .retired(retired)
  );

  multicycle_ctrl #(.CNT_W(3)) dut_w (
    .clk(clk), .reset(reset), .run(run), .ROM_inst(ROM_inst), .status(status),
    .pc_en(unused_pc_en), .PCSrc(unused_pcsrc), .RegWrite(unused_rw), .ALUSrc(unused_src),
    .ALU_operation(unused_alu), .write(unused_wr), .MemtoReg(unused_m2r),
    .immselect(unused_imm), .halted(unused_halted), .retired(s_retired)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one instruction, then trace outputs until its pc_en (or HALT).
  // run is dropped and ROM_inst scrambled right after the latch edge.
  task automatic do_instr(input logic [31:0] inst, input logic [3:0] st);
    @(negedge clk);
    ROM_inst = inst;
    status   = st;
    run      = 1'b1;
    @(negedge clk);
    run      = 1'b0;
    ROM_inst = 32'hFFFF_FFFF;
    t_cycles = 1; n_pc = 0; n_rw = 0; n_wr = 0; n_pcsrc = 0; t_done = 1'b0;
    d_src = ALUSrc;
    d_imm = immselect;
    for (int k = 0; k < 8; k++) begin
      if (!t_done) begin
        t_cycles++;
        if (pc_en)    n_pc++;
        if (RegWrite) n_rw++;
        if (write)    n_wr++;
        if (PCSrc)    n_pcsrc++;
        if (pc_en || halted) begin
          t_done  = 1'b1;
          f_alu   = ALU_operation;
          f_src   = ALUSrc;
          f_m2r   = MemtoReg;
          f_imm   = immselect;
          f_pcsrc = PCSrc;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  logic [31:0] alu_inst [9] = '{32'h002081B3, 32'h402081B3, 32'h0020F1B3, 32'h0020E1B3,
                                32'h0020A1B3, 32'h002091B3, 32'h40008093, 32'h0000E093,
                                32'h00009093};
  logic [3:0]  alu_exp  [9] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b0010,
                                4'b0010, 4'b0001, 4'b0010};
  logic        alu_src  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    reset = 1'b1; run = 1'b0; ROM_inst = 32'h0; status = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_pc_en", 32'(pc_en), 32'h0);
    chk("rst_regwrite", 32'(RegWrite), 32'h0);
    chk("rst_write", 32'(write), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_retired", 32'(retired), 32'h0);
    chk("rst_aluop", 32'(ALU_operation), 32'h2);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_retired", 32'(retired), 32'h0);
    chk("idle_pc_en", 32'(pc_en), 32'h0);

    // ADD x3,x1,x2
    do_instr(32'h002081B3, 4'h0);
    chk("add_cycles", 32'(t_cycles), 32'd4);
    chk("add_pc_en", 32'(n_pc), 32'd1);
    chk("add_regwrite", 32'(n_rw), 32'd1);
    chk("add_memtoreg", 32'(f_m2r), 32'h1);
    chk("add_aluop", 32'(f_alu), 32'h2);
    chk("add_alusrc", 32'(f_src), 32'h0);
    @(negedge clk);
    chk("add_retired", 32'(retired), 32'd1);

    // LW x5,8(x0)
    do_instr(32'h00802283, 4'h0);
    chk("lw_cycles", 32'(t_cycles), 32'd5);
    chk("lw_write", 32'(n_wr), 32'd0);
    chk("lw_regwrite", 32'(n_rw), 32'd1);
    chk("lw_memtoreg", 32'(f_m2r), 32'h0);
    chk("lw_alusrc", 32'(f_src), 32'h1);
    chk("lw_alusrc_dec", 32'(d_src), 32'h1);
    chk("lw_imm", 32'(f_imm), 32'h0);
    @(negedge clk);
    chk("lw_retired", 32'(retired), 32'd2);

    // SW x5,4(x0)
    do_instr(32'h00502223, 4'h0);
    chk("sw_cycles", 32'(t_cycles), 32'd4);
    chk("sw_write", 32'(n_wr), 32'd1);
    chk("sw_regwrite", 32'(n_rw), 32'd0);
    chk("sw_imm", 32'(f_imm), 32'h1);
    chk("sw_imm_dec", 32'(d_imm), 32'h1);
    chk("sw_alusrc", 32'(f_src), 32'h1);
    @(negedge clk);
    chk("sw_write_after", 32'(write), 32'h0);
    chk("sw_retired", 32'(retired), 32'd3);

    // Branches: BEQ taken/not, BNE taken, BLT never taken
    do_instr(32'h00000063, 4'b0100);
    chk("beq_t_cycles", 32'(t_cycles), 32'd3);
    chk("beq_t_pcsrc", 32'(f_pcsrc), 32'h1);
    chk("beq_t_aluop", 32'(f_alu), 32'h6);
    chk("beq_t_imm", 32'(f_imm), 32'h2);
    chk("beq_t_pc_en", 32'(n_pc), 32'd1);
    do_instr(32'h00000063, 4'b0000);
    chk("beq_nt_cycles", 32'(t_cycles), 32'd3);
    chk("beq_nt_pcsrc", 32'(n_pcsrc), 32'd0);
    do_instr(32'h00001063, 4'b0000);
    chk("bne_t_pcsrc", 32'(f_pcsrc), 32'h1);
    do_instr(32'h00004063, 4'b0100);
    chk("blt_nt_pcsrc", 32'(n_pcsrc), 32'd0);
    chk("blt_pc_en", 32'(n_pc), 32'd1);
    @(negedge clk);
    chk("br_retired", 32'(retired), 32'd7);

    // ALU decode table (R and I-ALU)
    for (int i = 0; i < 9; i++) begin
      do_instr(alu_inst[i], 4'h0);
      chk("alu_cycles", 32'(t_cycles), 32'd4);
      chk("alu_op", 32'(f_alu), 32'(alu_exp[i]));
      chk("alu_src", 32'(f_src), 32'(alu_src[i]));
      chk("alu_src_dec", 32'(d_src), 32'(alu_src[i]));
      chk("alu_m2r", 32'(f_m2r), 32'h1);
    end
    @(negedge clk);
    chk("alu_retired", 32'(retired), 32'd16);

    // Unknown opcode parks in HALT
    do_instr(32'h0000007F, 4'h0);
    chk("halt_halted", 32'(halted), 32'h1);
    chk("halt_pc_en", 32'(n_pc), 32'd0);
    ROM_inst = 32'h002081B3;
    run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("halt_stay", 32'({halted, pc_en, RegWrite, write}), 32'b1000);
    end
    chk("halt_retired", 32'(retired), 32'd16);
    chk("halt_aluop", 32'(ALU_operation), 32'h2);
    run = 1'b0;
    #1 reset = 1'b1;
    #1 chk("halt_rst_halted", 32'(halted), 32'h0);
    chk("halt_rst_retired", 32'(retired), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset during STORE MEM aborts it
    @(negedge clk);
    ROM_inst = 32'h00502223; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_write_mem", 32'(write), 32'h1);
    #1 reset = 1'b1;
    #1 chk("abort_write", 32'(write), 32'h0);
    chk("abort_pc_en", 32'(pc_en), 32'h0);
    @(negedge clk);
    chk("abort_retired", 32'(retired), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_idle", 32'({pc_en, write, RegWrite}), 32'h0);

    // Wrap: narrow counter rolls 7 -> 0 on the eighth instruction
    for (int i = 0; i < 7; i++) do_instr(32'h00000063, 4'h0);
    @(negedge clk);
    chk("wrap_pre", 32'(s_retired), 32'd7);
    do_instr(32'h00000063, 4'h0);
    @(negedge clk);
    chk("wrap_zero", 32'(s_retired), 32'd0);
    chk("wrap_wide", 32'(retired), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
